// File: rtl/dmem_ctrl.sv
// ============================================================================
// Module   : dmem_ctrl
// Brief    : Core data-port to req/ack word-memory bridge with sizing, load
//            extension, sub-word read-modify-write, misalign and ack timeout.
//            Optional macro DMEM_WSTRB_EN: byte strobes replace the RMW path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    output logic [31:0]       rdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
`ifdef DMEM_WSTRB_EN
    output logic [3:0]        mem_wstrb_o,
`endif
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int c_CNT_W = $clog2(TIMEOUT);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_RD     = 3'd1;
    localparam logic [2:0] c_ST_RMW_RD = 3'd2;
    localparam logic [2:0] c_ST_RMW_WR = 3'd3;
    localparam logic [2:0] c_ST_WR     = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;
    localparam logic [2:0] c_ST_ERR    = 3'd6;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic [31:0]        r_wdata;
    logic [31:0]        r_merged;
    logic [31:0]        r_rdata;
    logic [c_CNT_W-1:0] r_cnt;

    logic        w_misaligned;
    logic        w_mem_phase;
    logic        w_ack;
    logic        w_timeout;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic [4:0]  w_shamt;
    logic [31:0] w_mask;
    logic [31:0] w_merged;
    logic [31:0] w_wr_data;

    assign w_misaligned = ((size_i == 2'b01) && addr_i[0]) ||
                          (size_i[1] && (addr_i[1:0] != 2'b00));
    assign w_mem_phase  = (r_state == c_ST_RD) || (r_state == c_ST_RMW_RD) ||
                          (r_state == c_ST_RMW_WR) || (r_state == c_ST_WR);
    // Acks outside a memory phase are stray and must not move the FSM.
    assign w_ack        = mem_ack_i && w_mem_phase;
    assign w_timeout    = w_mem_phase && !mem_ack_i &&
                          (r_cnt == c_CNT_W'(TIMEOUT - 1));

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = mem_rdata_i[7:0];
            2'd1:    w_byte = mem_rdata_i[15:8];
            2'd2:    w_byte = mem_rdata_i[23:16];
            default: w_byte = mem_rdata_i[31:24];
        endcase
        w_half = r_addr[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (r_size)
            2'b00:   w_load_ext = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
            2'b01:   w_load_ext = {{16{w_half[15] & ~r_unsigned}}, w_half};
            default: w_load_ext = mem_rdata_i;
        endcase
    end

    // Aligned half-words have addr[0]=0, so the byte shift also serves halves.
    assign w_shamt  = {r_addr[1:0], 3'b000};
    assign w_mask   = (r_size == 2'b00) ? (32'h0000_00FF << w_shamt) :
                      (r_size == 2'b01) ? (32'h0000_FFFF << w_shamt) : 32'hFFFF_FFFF;
    assign w_merged = (mem_rdata_i & ~w_mask) | ((r_wdata << w_shamt) & w_mask);

`ifdef DMEM_WSTRB_EN
    logic [3:0] w_strb;

    always_comb begin
        case (r_size)
            2'b00: begin
                w_wr_data = {4{r_wdata[7:0]}};
                w_strb    = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                w_wr_data = {2{r_wdata[15:0]}};
                w_strb    = 4'b0011 << r_addr[1:0];
            end
            default: begin
                w_wr_data = r_wdata;
                w_strb    = 4'b1111;
            end
        endcase
    end
`else
    assign w_wr_data = r_wdata;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (req_i) begin
                    if (w_misaligned) begin
                        w_next = c_ST_ERR;
                    end else if (!we_i) begin
                        w_next = c_ST_RD;
                    end else if (size_i[1]) begin
                        w_next = c_ST_WR;
                    end else begin
`ifdef DMEM_WSTRB_EN
                        w_next = c_ST_WR;
`else
                        w_next = c_ST_RMW_RD;
`endif
                    end
                end
            end
            c_ST_RD: begin
                if (w_ack)          w_next = c_ST_DONE;
                else if (w_timeout) w_next = c_ST_ERR;
            end
            c_ST_RMW_RD: begin
                if (w_ack)          w_next = c_ST_RMW_WR;
                else if (w_timeout) w_next = c_ST_ERR;
            end
            c_ST_RMW_WR, c_ST_WR: begin
                if (w_ack)          w_next = c_ST_DONE;
                else if (w_timeout) w_next = c_ST_ERR;
            end
            default: w_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_wdata    <= '0;
            r_merged   <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
        end else begin
            if ((r_state == c_ST_IDLE) && req_i && !w_misaligned) begin
                r_addr     <= addr_i;
                r_size     <= size_i;
                r_unsigned <= unsigned_i;
                r_wdata    <= wdata_i;
            end
            if ((w_next != r_state) || w_ack) begin
                r_cnt <= '0;
            end else if (w_mem_phase) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
            if (w_ack && (r_state == c_ST_RD)) begin
                r_rdata <= w_load_ext;
            end
            if (w_ack && (r_state == c_ST_RMW_RD)) begin
                r_merged <= w_merged;
            end
            if (w_ack && ((r_state == c_ST_RMW_WR) || (r_state == c_ST_WR))) begin
                r_rdata <= '0;
            end
            if (w_next == c_ST_ERR) begin
                r_rdata <= '0;
            end
        end
    end

    assign mem_addr_o = {r_addr[ADDR_W-1:2], 2'b00};
    assign rdata_o    = r_rdata;

    always_comb begin
        busy_o      = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
`ifdef DMEM_WSTRB_EN
        mem_wstrb_o = 4'b0000;
`endif
        case (r_state)
            c_ST_IDLE: busy_o = req_i;
            c_ST_RD, c_ST_RMW_RD: begin
                busy_o    = 1'b1;
                mem_req_o = 1'b1;
            end
            c_ST_RMW_WR: begin
                busy_o      = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_wdata_o = r_merged;
            end
            c_ST_WR: begin
                busy_o      = 1'b1;
                mem_req_o   = 1'b1;
                mem_we_o    = 1'b1;
                mem_wdata_o = w_wr_data;
`ifdef DMEM_WSTRB_EN
                mem_wstrb_o = w_strb;
`endif
            end
            c_ST_DONE: done_o = 1'b1;
            c_ST_ERR:  err_o  = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
// ============================================================================
// Module   : tb_dmem_ctrl
// Brief    : Self-checking bench for dmem_ctrl: vector table, corner-case
//            sequences and randomized accesses against a byte-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_ctrl;

    localparam int ADDR_W  = 32;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0, we_i = 1'b0, unsigned_i = 1'b0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic [1:0]  size_i = 2'b00;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
    logic        busy_o, done_o, err_o, mem_req_o, mem_we_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
`ifdef DMEM_WSTRB_EN
    logic [3:0]  mem_wstrb_o;
`endif

    always #5 clk = ~clk;

    dmem_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .size_i(size_i), .unsigned_i(unsigned_i),
        .rdata_o(rdata_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
`ifdef DMEM_WSTRB_EN
        .mem_wstrb_o(mem_wstrb_o),
`endif
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    // Memory responder state; the responder is the only writer of mem.
    logic [31:0] mem [0:1023];
    int          lat = 2;
    bit          ack_en = 1'b1, ack_writes = 1'b1;
    int          stray_req = 0, stray_done = 0, pl_req = 0, pl_done = 0;
    logic [31:0] pl_addr = '0, pl_data = '0;
    int          rd_cnt = 0, wr_cnt = 0, stab_err = 0, wcnt = 0;
    logic [31:0] last_wdata = '0, h_addr = '0, h_wdata = '0;
    logic        h_we = 1'b0;
    logic [3:0]  last_wstrb = 4'b0000;

    int n_cmp = 0, n_fail = 0;

    always @(negedge clk) begin
        mem_ack_i   = 1'b0;
        mem_rdata_i = $urandom;
        if (pl_req != pl_done) begin
            mem[pl_addr[11:2]] = pl_data;
            pl_done = pl_req;
        end
        if (stray_req != stray_done) begin
            stray_done = stray_req;
            mem_ack_i  = 1'b1;
            wcnt       = 0;
        end else if (mem_req_o && !rst) begin
            wcnt++;
            if (wcnt > 1 && (mem_addr_o !== h_addr || mem_we_o !== h_we ||
                             (mem_we_o && mem_wdata_o !== h_wdata)))
                stab_err++;
            h_addr = mem_addr_o; h_we = mem_we_o; h_wdata = mem_wdata_o;
            if (ack_en && wcnt >= lat && (!mem_we_o || ack_writes)) begin
                mem_ack_i = 1'b1;
                wcnt      = 0;
                if (mem_we_o) begin
                    wr_cnt++;
                    last_wdata = mem_wdata_o;
`ifdef DMEM_WSTRB_EN
                    last_wstrb = mem_wstrb_o;
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb_o[b])
                            mem[mem_addr_o[11:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
`else
                    mem[mem_addr_o[11:2]] = mem_wdata_o;
`endif
                end else begin
                    rd_cnt++;
                    mem_rdata_i = mem[mem_addr_o[11:2]];
                end
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pl_addr = a; pl_data = d; pl_req++;
        @(negedge clk);
    endtask

    // One core access: request held until done/err, like a stalled core.
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input bit uns,
                          output bit d_seen, output bit e_seen, output logic [31:0] rd,
                          output int req_cyc, output int busy_bad, output logic [31:0] last_a);
        d_seen = 0; e_seen = 0; rd = '0; req_cyc = 0; busy_bad = 0; last_a = '0;
        @(negedge clk);
        we_i = we; addr_i = addr; wdata_i = wdata; size_i = size; unsigned_i = uns;
        req_i = 1'b1;
        #1;
        if (!busy_o) busy_bad++;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (mem_req_o) begin req_cyc++; last_a = mem_addr_o; end
            if (done_o || err_o) begin
                d_seen = done_o; e_seen = err_o; rd = rdata_o;
                if (busy_o) busy_bad++;
                break;
            end
            if (!busy_o) busy_bad++;
        end
        req_i = 1'b0;
        if (!d_seen && !e_seen) begin
            n_cmp++; n_fail++;
            $display("FAIL access_budget: no done/err within 64 cycles, addr 0x%08h", addr);
        end
    endtask

    function automatic logic [31:0] ref_load(logic [31:0] word, int lane, logic [1:0] size, bit uns);
        longint v;
        case (size)
            2'd0: begin v = longint'((word >> (8*lane)) & 32'hFF);   if (!uns && v >= 128)   v -= 256;   end
            2'd1: begin v = longint'((word >> (8*lane)) & 32'hFFFF); if (!uns && v >= 32768) v -= 65536; end
            default: v = longint'(word);
        endcase
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_store(logic [31:0] word, int lane, logic [1:0] size, logic [31:0] wd);
        logic [31:0] r = word;
        int nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        for (int k = 0; k < nb; k++) r[8*(lane+k) +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] init;
        logic [31:0] exp_rd;
        bit          exp_err;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t        vt [14];
    logic [31:0] ref_mem [16];

    initial begin
        bit d, e;
        logic [31:0] rd, la;
        int rc, bb, r0, w0, bad;
        bit found;

        vt[0]  = '{1'b0, 32'h100, 32'h0,        2'd2, 1'b0, 32'h8000_00F0, 32'h8000_00F0, 1'b0, 32'h8000_00F0};
        vt[1]  = '{1'b0, 32'h103, 32'h0,        2'd0, 1'b0, 32'h8012_3456, 32'hFFFF_FF80, 1'b0, 32'h8012_3456};
        vt[2]  = '{1'b0, 32'h103, 32'h0,        2'd0, 1'b1, 32'h8012_3456, 32'h0000_0080, 1'b0, 32'h8012_3456};
        vt[3]  = '{1'b0, 32'h102, 32'h0,        2'd1, 1'b0, 32'h7FFF_0000, 32'h0000_7FFF, 1'b0, 32'h7FFF_0000};
        vt[4]  = '{1'b0, 32'h100, 32'h0,        2'd1, 1'b0, 32'h1234_ABCD, 32'hFFFF_ABCD, 1'b0, 32'h1234_ABCD};
        vt[5]  = '{1'b0, 32'h100, 32'h0,        2'd1, 1'b1, 32'h1234_ABCD, 32'h0000_ABCD, 1'b0, 32'h1234_ABCD};
        vt[6]  = '{1'b1, 32'h201, 32'h0000_00AB, 2'd0, 1'b0, 32'h1122_3344, 32'h0,         1'b0, 32'h1122_AB44};
        vt[7]  = '{1'b1, 32'h202, 32'h0000_BEEF, 2'd1, 1'b0, 32'h1122_3344, 32'h0,         1'b0, 32'hBEEF_3344};
        vt[8]  = '{1'b1, 32'h204, 32'hCAFE_F00D, 2'd2, 1'b0, 32'h1122_3344, 32'h0,         1'b0, 32'hCAFE_F00D};
        vt[9]  = '{1'b0, 32'h102, 32'h0,        2'd2, 1'b0, 32'h1234_5678, 32'h0,         1'b1, 32'h1234_5678};
        vt[10] = '{1'b0, 32'h101, 32'h0,        2'd1, 1'b0, 32'h1234_5678, 32'h0,         1'b1, 32'h1234_5678};
        vt[11] = '{1'b0, 32'h300, 32'h0,        2'd3, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
        vt[12] = '{1'b0, 32'h301, 32'h0,        2'd0, 1'b0, 32'h0000_7F00, 32'h0000_007F, 1'b0, 32'h0000_7F00};
        vt[13] = '{1'b1, 32'h206, 32'h0000_FFFF, 2'd2, 1'b0, 32'h5566_7788, 32'h0,         1'b1, 32'h5566_7788};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_ctrl", {28'h0, busy_o, done_o, err_o, mem_req_o}, 32'h0);
        chk("rst_mem_we", {31'h0, mem_we_o}, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_wdata", mem_wdata_o, 32'h0);
`ifdef DMEM_WSTRB_EN
        chk("rst_wstrb", {28'h0, mem_wstrb_o}, 32'h0);
`endif
        rst = 1'b0;

        // Vector table
        lat = 2;
        for (int i = 0; i < 14; i++) begin
            preload(vt[i].addr, vt[i].init);
            access(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].size, vt[i].uns, d, e, rd, rc, bb, la);
            chk($sformatf("v%0d_done", i), {31'h0, d}, {31'h0, ~vt[i].exp_err});
            chk($sformatf("v%0d_err", i), {31'h0, e}, {31'h0, vt[i].exp_err});
            chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("v%0d_busy", i), bb, 0);
            if (vt[i].exp_err) chk($sformatf("v%0d_noreq", i), rc, 0);
            else               chk($sformatf("v%0d_addr", i), la, {vt[i].addr[31:2], 2'b00});
            chk($sformatf("v%0d_mem", i), mem[vt[i].addr[11:2]], vt[i].exp_mem);
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), {30'h0, done_o, err_o}, 32'h0);
        end

        // Sub-word store: phase count and write-beat contents
        preload(32'h200, 32'h1122_3344);
        r0 = rd_cnt; w0 = wr_cnt;
        access(1'b1, 32'h201, 32'h0000_00AB, 2'd0, 1'b0, d, e, rd, rc, bb, la);
        chk("sb_writes", wr_cnt - w0, 1);
`ifdef DMEM_WSTRB_EN
        chk("sb_reads", rd_cnt - r0, 0);
        chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
        chk("sb_wstrb", {28'h0, last_wstrb}, 32'h2);
        chk("sb_req_cycles", rc, 2);
`else
        chk("sb_reads", rd_cnt - r0, 1);
        chk("sb_wdata", last_wdata, 32'h1122_AB44);
        chk("sb_req_cycles", rc, 4);
`endif
        chk("sb_done", {31'h0, d}, 32'h1);

        // Load timeout, then a stray ack in IDLE
        ack_en = 1'b0;
        access(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, d, e, rd, rc, bb, la);
        chk("to_err", {31'h0, e}, 32'h1);
        chk("to_nodone", {31'h0, d}, 32'h0);
        chk("to_req_cycles", rc, TIMEOUT);
        chk("to_rdata", rd, 32'h0);
        ack_en = 1'b1;
        stray_req++;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_o || err_o || busy_o || mem_req_o) bad++;
        end
        chk("stray_ack_ignored", bad, 0);

        // Sub-word store timing out before any write: memory untouched
        preload(32'h210, 32'hA1B2_C3D4);
        ack_en = 1'b0;
        access(1'b1, 32'h212, 32'h0000_1234, 2'd1, 1'b0, d, e, rd, rc, bb, la);
        ack_en = 1'b1;
        chk("to_sh_err", {31'h0, e}, 32'h1);
        chk("to_sh_mem", mem[32'h210 >> 2], 32'hA1B2_C3D4);

        // Reset during the write phase of a sub-word store
        preload(32'h500, 32'h1122_3344);
        ack_writes = 1'b0;
        @(negedge clk);
        we_i = 1'b1; addr_i = 32'h501; wdata_i = 32'h55; size_i = 2'd0; unsigned_i = 1'b0;
        req_i = 1'b1;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_req_o && mem_we_o) begin found = 1; break; end
        end
        chk("rmw_reached_write", {31'h0, found}, 32'h1);
        rst = 1'b1; req_i = 1'b0;
        @(negedge clk);
        chk("rstmid_ctrl", {27'h0, busy_o, done_o, err_o, mem_req_o, mem_we_o}, 32'h0);
        chk("rstmid_addr", mem_addr_o, 32'h0);
        chk("rstmid_wdata", mem_wdata_o, 32'h0);
        chk("rstmid_rdata", rdata_o, 32'h0);
        rst = 1'b0; ack_writes = 1'b1;
        stray_req++;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_o || busy_o || mem_req_o) bad++;
        end
        chk("rstmid_idle", bad, 0);
        chk("rstmid_mem", mem[32'h500 >> 2], 32'h1122_3344);

        // Back-to-back SW then LW
        access(1'b1, 32'h500, 32'hA5A5_5A5A, 2'd2, 1'b0, d, e, rd, rc, bb, la);
        access(1'b0, 32'h500, 32'h0, 2'd2, 1'b0, d, e, rd, rc, bb, la);
        chk("sw_lw_rdata", rd, 32'hA5A5_5A5A);

        // Randomized accesses against the byte-level model
        for (int w = 0; w < 16; w++) begin
            ref_mem[w] = $urandom;
            preload(32'h400 + 32'(w * 4), ref_mem[w]);
        end
        for (int it = 0; it < 80; it++) begin
            bit          rwe, runs, mis;
            int          w, ln;
            logic [1:0]  rsz;
            logic [31:0] rwd, ra, exp_rd;
            rwe = 1'($urandom_range(0, 1)); runs = 1'($urandom_range(0, 1));
            w = $urandom_range(0, 15); ln = $urandom_range(0, 3);
            rsz = 2'($urandom_range(0, 3)); rwd = $urandom;
            lat = $urandom_range(1, 3);
            ra  = 32'h400 + 32'(w * 4 + ln);
            mis = (rsz == 2'd1 && (ln % 2) != 0) || (rsz >= 2'd2 && ln != 0);
            exp_rd = 32'h0;
            if (!mis && !rwe) exp_rd = ref_load(ref_mem[w], ln, rsz, runs);
            if (!mis && rwe)  ref_mem[w] = ref_store(ref_mem[w], ln, rsz, rwd);
            access(rwe, ra, rwd, rsz, runs, d, e, rd, rc, bb, la);
            chk($sformatf("r%0d_err", it), {31'h0, e}, {31'h0, mis});
            chk($sformatf("r%0d_rdata", it), rd, exp_rd);
            chk($sformatf("r%0d_mem", it), mem[ra[11:2]], ref_mem[w]);
        end

        chk("req_stability", stab_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the core's data port (ce/we/addr/wdata/rdata).
- Converts single-cycle core load/store requests into a req/ack transaction on a multi-cycle, word-wide data memory.
- Handles byte/half/word sizing, load sign/zero extension, read-modify-write for sub-word stores, misalignment detection and an ack timeout.
- Holds the core via busy_o until each access completes.

Parameters:
- ADDR_W, 32, byte-address width on both sides.
- TIMEOUT, 16, max cycles to wait for mem_ack_i per memory phase before aborting with error; must be >= 2.

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_i  input  1  core access request (data_ce)
- we_i  input  1  1 = store, 0 = load
- addr_i  input  ADDR_W  byte address
- wdata_i  input  32  store data, LSB-aligned
- size_i  input  2  00 byte, 01 half, 10 word; 11 treated as word
- unsigned_i  input  1  1 = zero-extend load (LBU/LHU)
- rdata_o  output  32  extended load result, valid when done_o=1
- busy_o  output  1  stall core
- done_o  output  1  one-cycle completion pulse
- err_o  output  1  one-cycle pulse: misaligned or timeout
- mem_req_o  output  1  memory request, held until ack
- mem_we_o  output  1  memory write enable
- mem_addr_o  output  ADDR_W  word-aligned address, bits [1:0] = 0
- mem_wdata_o  output  32  memory write data
- mem_rdata_i  input  32  memory read data, valid with mem_ack_i
- mem_ack_i  input  1  one-cycle acknowledge

Behaviour:
- Reset: state IDLE. rdata_o, busy_o, done_o, err_o, mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are all 0. Timeout counter is 0.
- Reset mid-transaction aborts immediately: mem_req_o is 0 after the edge, no done_o, and any late mem_ack_i is ignored in IDLE.
- States: IDLE, RD, RMW_RD, RMW_WR, WR, DONE, ERR.
- IDLE, req_i=0: busy_o=0.
- IDLE, req_i=1, misaligned (half with addr[0]=1; word with addr[1:0]!=0): go to ERR, busy_o=1 this cycle, no memory access.
- IDLE, req_i=1, aligned: latch addr, size, we, wdata, unsigned and assert busy_o combinationally in the same cycle.
  - Load -> RD.
  - Word store -> WR.
  - Byte or half store -> RMW_RD.
- RD / RMW_RD: mem_req_o=1, mem_we_o=0. On ack:
  - RD -> DONE, rdata_o registered as the extended result.
  - RMW_RD -> RMW_WR, with the merged word registered.
- RMW_WR / WR: mem_req_o=1, mem_we_o=1, mem_wdata_o = merged word (RMW_WR) or wdata (WR). On ack -> DONE.
- mem_addr_o = {latched_addr[ADDR_W-1:2], 2'b00}. It is stable, together with we and wdata, for as long as mem_req_o is high.
- DONE: done_o=1, busy_o=0, rdata_o held (0 for stores). Next state IDLE. A req_i present in DONE is not accepted until IDLE; the core sees the stall release and re-presents the request.
- ERR: err_o=1, busy_o=0, rdata_o=0, then IDLE.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Signed: replicate bit 7 (byte) or bit 15 (half). Unsigned: zero-fill.
  - Word: pass through.
- Store merge: replace only the addressed byte/half of the read word with wdata[7:0] or wdata[15:0]; other bytes are unchanged.
- Timeout:
  - Counter clears on entering any memory state and on each ack; it increments each cycle without an ack.
  - On reaching TIMEOUT-1 with no ack: drop mem_req_o and go to ERR.
  - A timed-out RMW leaves memory unchanged if it occurs in RMW_RD.
- mem_ack_i while mem_req_o=0 is ignored.
- Stores never change rdata_o except clearing it to 0 at DONE.

Optional Feature:
- Macro DMEM_WSTRB_EN.
- Defined: adds port mem_wstrb_o (output, 4) = byte enables. Sub-word stores go IDLE -> WR directly with the data replicated across lanes (byte: {4{b}}, half: {2{h}}) and the strobe selecting the lanes. RMW_RD/RMW_WR are unreachable. Word store strobe = 4'b1111; reads drive 4'b0000.
- Undefined: no mem_wstrb_o port; sub-word stores use the RMW sequence.

Test Plan:
- Word load, mem word 0x8000_00F0 at 0x100, ack after 2 cycles -> mem_addr_o=0x100, done_o pulses, rdata_o=0x8000_00F0; busy_o high from request cycle until DONE.
- LB/LBU at 0x103, mem word 0x80xx_xxxx -> LB rdata_o=0xFFFF_FF80, LBU rdata_o=0x0000_0080; LH at 0x102 with word 0x7FFF_0000 -> 0x0000_7FFF.
- SB 0xAB to 0x201, memory 0x1122_3344 (no WSTRB) -> one read, then write of 0x1122_AB44, done_o one cycle after write ack; with DMEM_WSTRB_EN -> single write, mem_wstrb_o=0010, mem_wdata_o=0xABAB_ABAB.
- LW at 0x102 or LH at 0x101 -> err_o pulses next cycle, mem_req_o never asserted, rdata_o=0.
- Load with ack withheld, TIMEOUT=16 -> mem_req_o drops after 16 cycles, err_o pulses, no done_o; a later stray ack is ignored.
- rst asserted in RMW_WR before ack -> all outputs 0 next cycle, state IDLE; back-to-back SW then LW to the same address returns the stored value.
